uart_conv8to16: RTL
===================

UART_CONV8TO16 -- requirements
Module: uart_conv8to16

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 100000, max clk cycles allowed between high and low byte of one word (valid range 2..2^20).
REQ-002 Port: clk  input  1  system clock; all logic on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: rx_data  input  8  byte from UART receiver, valid only while rx_done=1.
REQ-005 Port: rx_done  input  1  byte-received strobe; every high cycle counts as one byte.
REQ-006 Port: data  output  16  assembled word {high byte, low byte}; feeds demux tag/payload decode.
REQ-007 Port: conv8to16valid  output  1  one-cycle pulse, data holds a new word.
REQ-008 Port: drop_cnt  output  8  count of discarded partial words/bytes, saturating.
REQ-009 Port: busy  output  1  high while a high byte is held awaiting its low byte.

Function
REQ-010 The block SHALL implement a two-state FSM: WAIT_HI, WAIT_LO.
REQ-011 In WAIT_HI with rx_done=1, the block SHALL latch rx_data as the high byte, clear the timeout counter, and go to WAIT_LO.
REQ-012 In WAIT_LO with rx_done=1, the block SHALL register data={high byte, rx_data}, assert conv8to16valid on the next cycle for exactly one cycle, and go to WAIT_HI.
REQ-013 Latency SHALL be 1 cycle: conv8to16valid and new data appear on the clock edge after the low-byte rx_done cycle.
REQ-014 data SHALL hold its last value between pulses and SHALL change only together with a conv8to16valid pulse.
REQ-015 In WAIT_LO without rx_done, the timeout counter SHALL increment each cycle; at count TIMEOUT_CYCLES-1 the block SHALL discard the high byte, increment drop_cnt, and go to WAIT_HI.
REQ-016 rx_done in the same cycle as the timeout expiry SHALL win: the word is completed and drop_cnt is unchanged.
REQ-017 drop_cnt SHALL saturate at 255 and never wrap.
REQ-018 busy SHALL equal 1 exactly when the FSM is in WAIT_LO.
REQ-019 Back-to-back rx_done on consecutive cycles SHALL be accepted as consecutive bytes without loss.

Reset
REQ-020 With rst=1 at a rising edge, the block SHALL force FSM=WAIT_HI, data=16'h0000, conv8to16valid=0, drop_cnt=0, busy=0, timeout counter=0, high-byte register=0.
REQ-021 rst SHALL override rx_done in the same cycle; a held partial word SHALL be lost without incrementing drop_cnt.

Configuration
REQ-022 Macro UART_CONV_TAG_CHECK_EN SHALL select high-byte tag validation.
REQ-023 With UART_CONV_TAG_CHECK_EN defined, a byte arriving in WAIT_HI whose bits [7:4] are not 0x0, 0x3, 0x4, 0x5 or 0x6 SHALL be discarded (FSM stays WAIT_HI, drop_cnt increments) to realign byte framing.
REQ-024 Without UART_CONV_TAG_CHECK_EN, any byte arriving in WAIT_HI SHALL be accepted as a high byte.

Verification
REQ-025 rx_done bytes 0x31 then 0x23 -> data=0x3123, conv8to16valid high exactly one cycle, one cycle after 2nd rx_done.
REQ-026 Byte 0x50, then idle TIMEOUT_CYCLES cycles, then bytes 0x60, 0x10 -> no pulse for 0x50, drop_cnt=1, then data=0x6010.
REQ-027 Byte 0x31, low byte 0x02 in exactly the timeout-expiry cycle -> data=0x3102, drop_cnt=0.
REQ-028 Bytes 0xA5, 0x31, 0x23 -> with macro: data=0x3123, drop_cnt=1; without: data=0xA531, busy=1 holding 0x23.
REQ-029 Byte 0x31, rst one cycle, bytes 0x40, 0x05 -> data=0x4005, drop_cnt=0, no word containing 0x31.
REQ-030 300 timeouts in succession -> drop_cnt=255, stays 255.

Source files
------------

// File: rtl/uart_conv8to16_if.sv
// Byte-in / word-out bus for the UART 8-to-16 converter.
// master drives received bytes and observes words; slave is the converter.
interface uart_conv8to16_if;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic [15:0] data;
    logic        conv8to16valid;
    logic [7:0]  drop_cnt;
    logic        busy;

    modport master (
        output rx_data,
        output rx_done,
        input  data,
        input  conv8to16valid,
        input  drop_cnt,
        input  busy
    );

    modport slave (
        input  rx_data,
        input  rx_done,
        output data,
        output conv8to16valid,
        output drop_cnt,
        output busy
    );
endinterface

// File: rtl/uart_conv8to16.sv
// Pairs UART bytes into 16-bit words {high, low} with an inter-byte timeout.
// Optional UART_CONV_TAG_CHECK_EN: reject high bytes with an unknown tag nibble.
module uart_conv8to16 #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input logic             clk,
    input logic             rst,
    uart_conv8to16_if.slave bus
);
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        StWaitHi,
        StWaitLo
    } state_t;

    state_t          r_state;
    logic [7:0]      r_hi;
    logic [CntW-1:0] r_cnt;
    logic [15:0]     r_data;
    logic            r_valid;
    logic [7:0]      r_drop;

    state_t          w_state_next;
    logic [7:0]      w_hi_next;
    logic [CntW-1:0] w_cnt_next;
    logic [15:0]     w_data_next;
    logic            w_valid_next;
    logic            w_drop_inc;
    logic [7:0]      w_drop_next;
    logic            w_tag_ok;

`ifdef UART_CONV_TAG_CHECK_EN
    // Only tags the downstream demux understands may start a word.
    assign w_tag_ok = bus.rx_data[7:4] inside {4'h0, 4'h3, 4'h4, 4'h5, 4'h6};
`else
    assign w_tag_ok = 1'b1;
`endif

    always_comb begin
        w_state_next = r_state;
        w_hi_next    = r_hi;
        w_cnt_next   = r_cnt;
        w_data_next  = r_data;
        w_valid_next = 1'b0;
        w_drop_inc   = 1'b0;
        unique case (r_state)
            StWaitHi: begin
                if (bus.rx_done) begin
                    if (w_tag_ok) begin
                        w_hi_next    = bus.rx_data;
                        w_cnt_next   = '0;
                        w_state_next = StWaitLo;
                    end else begin
                        w_drop_inc = 1'b1;
                    end
                end
            end
            StWaitLo: begin
                // A low byte in the expiry cycle still completes the word.
                if (bus.rx_done) begin
                    w_data_next  = {r_hi, bus.rx_data};
                    w_valid_next = 1'b1;
                    w_state_next = StWaitHi;
                end else if (r_cnt == CntMax) begin
                    w_drop_inc   = 1'b1;
                    w_state_next = StWaitHi;
                end else begin
                    w_cnt_next = r_cnt + CntW'(1);
                end
            end
            default: w_state_next = StWaitHi;
        endcase
        w_drop_next = (w_drop_inc && (r_drop != 8'hFF)) ? r_drop + 8'd1 : r_drop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StWaitHi;
            r_hi    <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_drop  <= '0;
        end else begin
            r_state <= w_state_next;
            r_hi    <= w_hi_next;
            r_cnt   <= w_cnt_next;
            r_data  <= w_data_next;
            r_valid <= w_valid_next;
            r_drop  <= w_drop_next;
        end
    end

    assign bus.data           = r_data;
    assign bus.conv8to16valid = r_valid;
    assign bus.drop_cnt       = r_drop;
    assign bus.busy           = (r_state == StWaitLo);
endmodule
